// File: rtl/pic_irq_sequencer.sv
// 8-input fixed-priority interrupt sequencer: IRR/ISR tracking, two-pulse INTA
// acknowledge handshake, vector generation and EOI/AEOI handling.
module pic_irq_sequencer #(
    parameter bit INTA_EDGE_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic [7:0] imr,
    input  logic [4:0] vec_base,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic       vec_valid,
    output logic [7:0] vec,
    output logic [7:0] irr,
    output logic [7:0] isr
);

    typedef enum logic [1:0] {IDLE, ACK1, VEC} state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_d_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic       int_out_q, int_out_d;
    logic       vec_valid_q, vec_valid_d;
    logic [7:0] vec_q, vec_d;
    logic [2:0] cur_q, cur_d;
    logic       spur_q, spur_d;
    logic       inta_prev_q;
    logic       inta_smp;
    logic       inta_fall;

    // Returns 8 when no bit is set, so "index < low_idx(x)" is true for an empty x.
    function automatic logic [3:0] low_idx(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    generate
        if (INTA_EDGE_SYNC) begin : g_sync
            logic sync1_q, sync2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= inta_n;
                    sync2_q <= sync1_q;
                end
            end
            assign inta_smp = sync2_q;
        end else begin : g_nosync
            assign inta_smp = inta_n;
        end
    endgenerate

    assign inta_fall = inta_prev_q & ~inta_smp;

    logic [7:0] cand;
    logic [3:0] win_idx;
    logic [3:0] isr_low;
    logic [7:0] isr_set, isr_clr, irr_clr;

    always_comb begin
        cand        = irr_q & ~imr;
        win_idx     = low_idx(cand);
        isr_low     = low_idx(isr_q);
        state_d     = state_q;
        cur_d       = cur_q;
        spur_d      = spur_q;
        isr_set     = 8'h00;
        isr_clr     = 8'h00;
        irr_clr     = 8'h00;
        vec_valid_d = 1'b0;
        vec_d       = vec_q;

        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    // A request that vanished since int_out was raised is treated as spurious.
                    if (int_out_q && (cand != 8'h00)) begin
                        cur_d                 = win_idx[2:0];
                        spur_d                = 1'b0;
                        isr_set[win_idx[2:0]] = 1'b1;
                        irr_clr[win_idx[2:0]] = 1'b1;
                    end else begin
                        cur_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_fall) state_d = VEC;
            end
            VEC: begin
                state_d     = IDLE;
                vec_valid_d = 1'b1;
                vec_d       = {vec_base, cur_q};
                if (aeoi && !spur_q) isr_clr[cur_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (eoi_valid) begin
            if (eoi_specific)           isr_clr[eoi_level]    = 1'b1;
            else if (isr_q != 8'h00)    isr_clr[isr_low[2:0]] = 1'b1;
        end

        irr_d = (ltim ? ir : (irr_q | (ir & ~ir_d_q))) & ~irr_clr;
        // Set beats clear on the same bit.
        isr_d = (isr_q & ~isr_clr) | isr_set;

        int_out_d = (cand != 8'h00) && (state_q == IDLE) && (state_d == IDLE)
                    && (win_idx < isr_low);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ir_d_q      <= 8'h00;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            int_out_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_q       <= 8'h00;
            cur_q       <= 3'd0;
            spur_q      <= 1'b0;
            inta_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ir_d_q      <= ir;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            int_out_q   <= int_out_d;
            vec_valid_q <= vec_valid_d;
            vec_q       <= vec_d;
            cur_q       <= cur_d;
            spur_q      <= spur_d;
            inta_prev_q <= inta_smp;
        end
    end

    assign int_out   = int_out_q;
    assign vec_valid = vec_valid_q;
    assign vec       = vec_q;
    assign irr       = irr_q;
    assign isr       = isr_q;

endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the interrupt sequencer.
module tb_pic_irq_sequencer;
    localparam bit SYNC = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic       ltim, aeoi;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       inta_n;
    logic       eoi_valid, eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out, vec_valid;
    logic [7:0] vec, irr, isr;

    always #5 clk = ~clk;

    pic_irq_sequencer #(.INTA_EDGE_SYNC(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .aeoi(aeoi), .imr(imr),
        .vec_base(vec_base), .inta_n(inta_n), .eoi_valid(eoi_valid),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .int_out(int_out),
        .vec_valid(vec_valid), .vec(vec), .irr(irr), .isr(isr)
    );

    int n_chk = 0, n_err = 0;
    int vv_cnt = 0;
    logic [7:0] last_vec = 8'h00;

    // Reference model state: phase 0 = waiting, 1 = first ack seen, 2 = vector cycle.
    logic [7:0] m_irr, m_isr, m_ir_prev, m_vec;
    logic       m_int, m_vv, m_spur;
    logic [2:0] m_cur;
    int         m_phase;
    logic       m_s1, m_s2, m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_ir_prev = 0; m_vec = 0;
        m_int = 0; m_vv = 0; m_spur = 0; m_cur = 0; m_phase = 0;
        m_s1 = 1; m_s2 = 1; m_prev = 1;
    endtask

    task automatic model_step();
        logic       smp, fall, ack_ok;
        logic [7:0] cand, nirr, nisr;
        int         w, il, nphase;
        if (!rst_n) begin
            model_reset();
            return;
        end
        smp    = SYNC ? m_s2 : inta_n;
        fall   = m_prev && !smp;
        cand   = m_irr & ~imr;
        w      = lowest(cand);
        il     = lowest(m_isr);
        nphase = m_phase;
        nisr   = m_isr;
        nirr   = ltim ? ir : (m_irr | (ir & ~m_ir_prev));
        m_vv   = 0;
        if (eoi_valid) begin
            if (eoi_specific) nisr[eoi_level] = 0;
            else if (il < 8) nisr[il] = 0;
        end
        if (m_phase == 2) begin
            if (aeoi && !m_spur) nisr[m_cur] = 0;
            m_vv   = 1;
            m_vec  = {vec_base, m_cur};
            nphase = 0;
        end else if (m_phase == 1) begin
            if (fall) nphase = 2;
        end else if (fall) begin
            nphase = 1;
            ack_ok = m_int && (cand != 0);
            if (ack_ok) begin
                m_cur = 3'(w); m_spur = 0;
                nisr[w] = 1; nirr[w] = 0;
            end else begin
                m_cur = 3'd7; m_spur = 1;
            end
        end
        m_int     = (cand != 0) && (m_phase == 0) && (nphase == 0) && (w < il);
        m_phase   = nphase;
        m_irr     = nirr;
        m_isr     = nisr;
        m_ir_prev = ir;
        m_prev    = smp;
        m_s2      = m_s1;
        m_s1      = inta_n;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("int_out", int_out, m_int);
        chk("vec_valid", vec_valid, m_vv);
        chk("vec", vec, m_vec);
        chk("irr", irr, m_irr);
        chk("isr", isr, m_isr);
        if (vec_valid) begin
            vv_cnt++;
            last_vec = vec;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic inta_pulse();
        inta_n = 0; steps(2);
        inta_n = 1; steps(3);
    endtask

    task automatic ack_pair();
        inta_pulse();
        inta_pulse();
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        eoi_valid = 1; eoi_specific = spec; eoi_level = lvl;
        step();
        eoi_valid = 0; eoi_specific = 0; eoi_level = 0;
    endtask

    int vv0;

    initial begin
        rst_n = 0; ir = 0; ltim = 0; aeoi = 0; imr = 0; vec_base = 5'h08;
        inta_n = 1; eoi_valid = 0; eoi_specific = 0; eoi_level = 0;
        model_reset();
        steps(2);
        chk("rst_int_out", int_out, 0);
        chk("rst_vec", vec, 0);
        chk("rst_isr", isr, 0);
        rst_n = 1;
        steps(2);

        // Edge-triggered IR3, two acknowledges.
        ir = 8'h08; step();
        ir = 8'h00; step();
        chk("ir3_int_out", int_out, 1);
        inta_pulse();
        chk("ir3_isr", isr, 8'h08);
        chk("ir3_ack1_int", int_out, 0);
        vv0 = vv_cnt;
        inta_pulse();
        chk("ir3_vv_once", vv_cnt - vv0, 1);
        chk("ir3_vec", last_vec, 8'h43);
        eoi(0, 0);
        chk("ir3_eoi", isr, 8'h00);

        // Masked IR2 loses to IR4.
        imr = 8'h04; ir = 8'h14; steps(3);
        ack_pair();
        chk("mask_vec_lo", last_vec[2:0], 3'b100);
        chk("mask_irr", irr, 8'h04);
        ir = 8'h00;
        eoi(1, 3'd4);
        chk("mask_eoi", isr, 8'h00);

        // IR1 in service blocks IR5 until a non-specific EOI.
        ir = 8'h02; step();
        ir = 8'h00; steps(2);
        ack_pair();
        chk("nest_isr", isr, 8'h02);
        ir = 8'h20; steps(4);
        chk("nest_blocked", int_out, 0);
        eoi(0, 0);
        chk("nest_eoi_isr", isr, 8'h00);
        step();
        chk("nest_int_out", int_out, 1);
        ack_pair();
        ir = 8'h00;
        eoi(1, 3'd5);

        // Automatic EOI on IR0.
        aeoi = 1;
        ir = 8'h01; step();
        ir = 8'h00; steps(2);
        inta_pulse();
        chk("aeoi_ack1_isr", isr[0], 1);
        inta_pulse();
        chk("aeoi_after_isr", isr, 8'h00);
        aeoi = 0;

        // Level-mode request withdrawn before acknowledge.
        ltim = 1; ir = 8'h20; steps(3);
        chk("spur_int_up", int_out, 1);
        ir = 8'h00; steps(2);
        ack_pair();
        chk("spur_vec", last_vec, 8'h47);
        chk("spur_isr", isr, 8'h00);
        ltim = 0;

        // Reset in the middle of an acknowledge.
        inta_pulse();
        #3 rst_n = 0;
        #1;
        chk("mid_rst_int", int_out, 0);
        chk("mid_rst_vv", vec_valid, 0);
        chk("mid_rst_vec", vec, 0);
        chk("mid_rst_irr", irr, 0);
        chk("mid_rst_isr", isr, 0);
        step();
        rst_n = 1;
        step();
        vv0 = vv_cnt;
        ack_pair();
        chk("post_rst_vv", vv_cnt - vv0, 1);
        chk("post_rst_vec", last_vec, 8'h47);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) ir = 8'($urandom_range(255));
            if ($urandom_range(15) == 0) imr = 8'($urandom_range(255));
            if ($urandom_range(63) == 0) ltim = ~ltim;
            if ($urandom_range(31) == 0) aeoi = ~aeoi;
            if ($urandom_range(7) == 0) vec_base = 5'($urandom_range(31));
            if ($urandom_range(3) == 0) inta_n = ~inta_n;
            eoi_valid    = ($urandom_range(7) == 0);
            eoi_specific = 1'($urandom_range(1));
            eoi_level    = 3'($urandom_range(7));
            if ($urandom_range(400) == 0) begin
                rst_n = 0;
                step();
                rst_n = 1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
